ti_psg_writer: RTL and testbench
================================

TI_PSG_WRITER -- requirements
Module: ti_psg_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, minimum strobe-high cycles after each write strobe (>=1).
REQ-003 SHALL have port CLK  in  1  single clock, all logic on posedge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port CMD_VALID  in  1  host offers a command.
REQ-006 SHALL have port CMD_READY  out  1  FIFO can accept; combinational = !full && !RST.
REQ-007 SHALL have port CMD_CH  in  2  target channel 0-3.
REQ-008 SHALL have port CMD_VOL  in  1  1 = attenuation write, 0 = tone/noise write.
REQ-009 SHALL have port CMD_VAL  in  10  tone period, or attenuation/noise in low bits.
REQ-010 SHALL have port READY  in  1  PSG ready flag; low = PSG busy latching.
REQ-011 SHALL have port D  out  8  PSG data bus, registered.
REQ-012 SHALL have port nWE  out  1  PSG write enable, active-low, registered.
REQ-013 SHALL have port nCE  out  1  PSG chip enable, active-low, registered, always equal to nWE.
REQ-014 SHALL have port BUSY  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-015 SHALL push {CMD_CH, CMD_VOL, CMD_VAL} into the FIFO on any edge with CMD_VALID && CMD_READY; CMD_VALID while full SHALL be ignored without corrupting the FIFO.
REQ-016 SHALL encode the latch byte as {1, CMD_CH, CMD_VOL, nibble}: nibble = VAL[3:0] for volume and tone, {0, VAL[2:0]} for noise (CH=3, VOL=0).
REQ-017 SHALL encode the data byte as {0, 0, VAL[9:4]}, sent only for tone writes (CH 0-2, VOL=0); volume and noise writes SHALL be single-byte.
REQ-018 SHALL implement FSM states IDLE, SETUP1, STROBE1, HOLD1, SETUP2, STROBE2, HOLD2.
REQ-019 IDLE: when FIFO non-empty, pop head into working register, drive D = latch byte, go SETUP1; else stay, nWE=nCE=1.
REQ-020 SETUPn: D stable, strobes high; go STROBEn on an edge where READY=1, else stay.
REQ-021 STROBEn: nWE=nCE=0 for exactly one cycle with D stable; next edge go HOLDn.
REQ-022 HOLDn: strobes high, D held; leave after GAP_CYCLES cycles in HOLDn AND READY=1; HOLD1 goes SETUP2 (D = data byte) for two-byte commands, else IDLE; HOLD2 goes IDLE.
REQ-023 Latency: command accepted at edge t into idle empty block with READY=1 SHALL produce strobe low during cycle t+2..t+3.
REQ-024 Strobes SHALL never be low on two consecutive cycles; D SHALL not change in the cycle before, during or after a strobe.
REQ-025 Simultaneous push and pop on a full FIFO SHALL be disallowed by CMD_READY=0; push and pop on a non-full FIFO in one edge SHALL keep occupancy unchanged.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; commands SHALL be issued strictly in acceptance order.
REQ-027 READY held low indefinitely SHALL stall in SETUPn/HOLDn with no strobe; no timeout.

Reset
REQ-028 While RST=1 at an edge: FSM=IDLE, FIFO emptied, D=8'h00, nWE=nCE=1, BUSY=0, gap counter cleared.
REQ-029 RST mid-transfer (any state) SHALL abandon the current command and all queued commands; no strobe SHALL occur on the cycle after the reset edge.
REQ-030 CMD_READY SHALL be 0 while RST=1 and 1 on the first cycle after RST deasserts.

Verification
REQ-031 Tone ch0 VAL=10'h1AC, READY=1 -> one strobe D=8'h8C, gap, one strobe D=8'h1A, BUSY falls after HOLD2.
REQ-032 Volume ch2 VAL=4'h5 -> single strobe D=8'hD5, no second byte; noise ch3 VAL=10'h3FE -> single strobe D=8'hE6.
REQ-033 Push FIFO_DEPTH+1 commands back-to-back with READY=1 -> CMD_READY low after 4th accept, 5th held off, all strobes emitted in order.
REQ-034 READY forced low for 10 cycles during SETUP1 -> no strobe until READY=1, then strobe on the following cycle; READY low in HOLD1 extends HOLD1.
REQ-035 Connected to PSG model: tone1 write VAL=10'h11D then vol1=4'h3 -> PSG tone1 register = 10'h11D, vol1 = 4'h3.
REQ-036 Assert RST during STROBE1 of a tone write -> nWE/nCE high next cycle, FIFO empty, no data byte issued after release.

Source files
------------

// File: rtl/ti_psg_writer.sv
// ti_psg_writer: queues PSG register commands and serialises them onto the
// SN76489-style write bus (latch byte, optional data byte) with READY handshake.
module ti_psg_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_CH,
  input  logic       CMD_VOL,
  input  logic [9:0] CMD_VAL,
  input  logic       READY,
  output logic [7:0] D,
  output logic       nWE,
  output logic       nCE,
  output logic       BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef struct packed {
    logic [1:0] ch;
    logic       vol;
    logic [9:0] val;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, SETUP1, STROBE1, HOLD1, SETUP2, STROBE2, HOLD2
  } state_t;

  // Only tone writes (channels 0-2, not volume) carry the upper period bits.
  function automatic logic two_byte(input cmd_t c);
    return !c.vol && (c.ch != 2'd3);
  endfunction

  // Noise control only has three meaningful bits; bit 3 is forced low.
  function automatic logic [7:0] latch_byte(input cmd_t c);
    logic [3:0] nib;
    nib = (!c.vol && c.ch == 2'd3) ? {1'b0, c.val[2:0]} : c.val[3:0];
    return {1'b1, c.ch, c.vol, nib};
  endfunction

  function automatic logic [7:0] data_byte(input cmd_t c);
    return {2'b00, c.val[9:4]};
  endfunction

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head, work;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push, pop, ld_data;
  state_t        state, next;
  logic [GW-1:0] gap_cnt;
  logic          gap_done, we_n;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign CMD_READY = !full && !RST;
  assign push      = CMD_VALID && CMD_READY;
  assign head      = mem[rd_ptr];
  assign gap_done  = (gap_cnt == GAP_LAST);
  assign BUSY      = !empty || (state != IDLE);
  assign nWE       = we_n;
  assign nCE       = we_n;

  // Command storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= cmd_t'({CMD_CH, CMD_VOL, CMD_VAL});
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  // Next-state logic plus pop / data-byte load controls.
  always_comb begin
    next    = state;
    pop     = 1'b0;
    ld_data = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop  = 1'b1;
        next = SETUP1;
      end
      SETUP1:  if (READY) next = STROBE1;
      STROBE1: next = HOLD1;
      HOLD1: if (gap_done && READY) begin
        if (two_byte(work)) begin
          next    = SETUP2;
          ld_data = 1'b1;
        end else begin
          next = IDLE;
        end
      end
      SETUP2:  if (READY) next = STROBE2;
      STROBE2: next = HOLD2;
      HOLD2:   if (gap_done && READY) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Registered bus outputs, working command and post-strobe gap counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      D       <= 8'h00;
      we_n    <= 1'b1;
      work    <= '0;
      gap_cnt <= '0;
    end else begin
      // Strobe is low exactly for the cycle spent in a STROBE state.
      we_n <= !((next == STROBE1) || (next == STROBE2));
      if (pop) begin
        work <= head;
        D    <= latch_byte(head);
      end else if (ld_data) begin
        D    <= data_byte(work);
      end
      // Count completed cycles while lingering in HOLD; saturate at the target.
      if ((state == HOLD1 || state == HOLD2) && next == state) begin
        if (!gap_done) gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ti_psg_writer.sv
// Directed bench for ti_psg_writer: bus timing, encoding, FIFO flow control,
// READY stalls, a behavioural PSG register model and mid-transfer reset.
module tb_ti_psg_writer;
  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, cmd_vol, ready, nwe, nce, busy;
  logic [1:0] cmd_ch;
  logic [9:0] cmd_val;
  logic [7:0] d;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  ti_psg_writer #(.FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_CH(cmd_ch), .CMD_VOL(cmd_vol), .CMD_VAL(cmd_val), .READY(ready),
    .D(d), .nWE(nwe), .nCE(nce), .BUSY(busy)
  );

  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  logic [9:0] psg_tone[4];
  logic [3:0] psg_vol[4];
  logic [2:0] psg_noise;
  logic [1:0] psg_ch;
  logic       prev_low = 1'b0;
  logic       rst_prev = 1'b0;
  logic [7:0] prev_d = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor mid-cycle: logs strobed bytes, drives the PSG model, checks strobe rules.
  always @(negedge clk) begin
    check("nce_eq_nwe", 32'(nce), 32'(nwe));
    if (prev_low) begin
      check("no_double_strobe", 32'(nwe), 32'd1);
      if (!rst_prev) check("d_after_strobe", 32'(d), 32'(prev_d));
    end
    if (nwe === 1'b0) begin
      log_q.push_back(d);
      if (d[7]) begin
        psg_ch = d[6:5];
        if (d[4])                psg_vol[psg_ch] = d[3:0];
        else if (psg_ch == 2'd3) psg_noise = d[2:0];
        else                     psg_tone[psg_ch][3:0] = d[3:0];
      end else begin
        psg_tone[psg_ch][9:4] = d[5:0];
      end
    end
    prev_low = (nwe === 1'b0);
    prev_d   = d;
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] ch, input logic vol, input logic [9:0] val);
    cmd_ch  = ch;
    cmd_vol = vol;
    cmd_val = val;
  endtask

  task automatic push_cmd(input logic [1:0] ch, input logic vol, input logic [9:0] val);
    set_cmd(ch, vol, val);
    check("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      step();
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s_count", tag), 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 4; i++) begin
      psg_tone[i] = '0;
      psg_vol[i]  = '0;
    end
    psg_noise = '0;
    psg_ch    = '0;
    rst = 1'b1; cmd_valid = 1'b0; ready = 1'b1;
    set_cmd(2'd0, 1'b0, 10'h000);

    // Reset state
    step(); step();
    check("rst_d", 32'(d), 32'h00);
    check("rst_nwe", 32'(nwe), 32'd1);
    check("rst_nce", 32'(nce), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Tone ch0 1AC: exact cycle timeline from acceptance edge t
    log_q.delete();
    set_cmd(2'd0, 1'b0, 10'h1AC);
    cmd_valid = 1'b1;
    step();                               // t
    cmd_valid = 1'b0;
    check("t0_busy", 32'(busy), 32'd1);
    check("t0_nwe", 32'(nwe), 32'd1);
    step();                               // t+1 SETUP1
    check("t1_d", 32'(d), 32'h8C);
    check("t1_nwe", 32'(nwe), 32'd1);
    step();                               // t+2 STROBE1
    check("t2_nwe", 32'(nwe), 32'd0);
    check("t2_d", 32'(d), 32'h8C);
    step();                               // t+3 HOLD1
    check("t3_nwe", 32'(nwe), 32'd1);
    check("t3_d", 32'(d), 32'h8C);
    step();                               // t+4 SETUP2
    check("t4_d", 32'(d), 32'h1A);
    check("t4_nwe", 32'(nwe), 32'd1);
    step();                               // t+5 STROBE2
    check("t5_nwe", 32'(nwe), 32'd0);
    step();                               // t+6 HOLD2
    check("t6_nwe", 32'(nwe), 32'd1);
    check("t6_busy", 32'(busy), 32'd1);
    step();                               // t+7 IDLE
    check("t7_busy", 32'(busy), 32'd0);
    exp_q = '{8'h8C, 8'h1A};
    check_log("tone0");

    // Volume ch2 and noise ch3 are single-byte writes
    log_q.delete();
    push_cmd(2'd2, 1'b1, 10'h005);
    push_cmd(2'd3, 1'b0, 10'h3FE);
    wait_idle();
    exp_q = '{8'hD5, 8'hE6};
    check_log("vol_noise");
    check("psg_vol2", 32'(psg_vol[2]), 32'h5);
    check("psg_noise_a", 32'(psg_noise), 32'h6);

    // FIFO fills behind a command stalled in SETUP1 by READY low
    log_q.delete();
    ready = 1'b0;
    push_cmd(2'd1, 1'b0, 10'h2B7);        // A
    step();                               // A popped, SETUP1
    check("a_setup_d", 32'(d), 32'hA7);
    cmd_valid = 1'b1;
    set_cmd(2'd0, 1'b1, 10'h001); step(); // B
    set_cmd(2'd3, 1'b0, 10'h005); step(); // C
    set_cmd(2'd3, 1'b1, 10'h00F); step(); // D
    set_cmd(2'd2, 1'b0, 10'h3C4); step(); // E
    check("full_after_4", 32'(cmd_ready), 32'd0);
    set_cmd(2'd1, 1'b1, 10'h00A);         // F offered while full
    for (int i = 0; i < 6; i++) begin
      check("held_off", 32'(cmd_ready), 32'd0);
      check("stall_setup1", 32'(nwe), 32'd1);
      step();
    end
    ready = 1'b1;
    step();
    check("strobe_after_ready", 32'(nwe), 32'd0);
    check("strobe_after_ready_d", 32'(d), 32'hA7);
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) begin
        step();
        acc = 1;
        break;
      end
      step();
    end
    cmd_valid = 1'b0;
    check("f_accepted", 32'(acc), 32'd1);
    wait_idle();
    exp_q = '{8'hA7, 8'h2B, 8'h91, 8'hE5, 8'hFF, 8'hC4, 8'h3C, 8'hBA};
    check_log("order");

    // READY low in HOLD1 keeps the latch byte on the bus
    log_q.delete();
    push_cmd(2'd2, 1'b0, 10'h055);        // t
    step();                               // t+1 SETUP1
    step();                               // t+2 STROBE1
    check("h_strobe", 32'(nwe), 32'd0);
    ready = 1'b0;
    step();                               // HOLD1
    for (int i = 0; i < 4; i++) begin
      check("hold1_d", 32'(d), 32'hC5);
      check("hold1_nwe", 32'(nwe), 32'd1);
      step();
    end
    ready = 1'b1;
    step();
    check("hold1_exit_d", 32'(d), 32'h05);
    wait_idle();
    exp_q = '{8'hC5, 8'h05};
    check_log("hold_ext");

    // PSG register model sees tone1 and vol1
    push_cmd(2'd1, 1'b0, 10'h11D);
    push_cmd(2'd1, 1'b1, 10'h003);
    wait_idle();
    check("psg_tone1", 32'(psg_tone[1]), 32'h11D);
    check("psg_vol1", 32'(psg_vol[1]), 32'h3);
    check("psg_noise_b", 32'(psg_noise), 32'h5);

    // Reset during STROBE1 abandons current and queued commands
    push_cmd(2'd0, 1'b0, 10'h1AC);        // t
    push_cmd(2'd0, 1'b1, 10'h007);        // t+1, tone popped
    step();                               // t+2 STROBE1
    check("r_strobe", 32'(nwe), 32'd0);
    rst = 1'b1;
    step();
    check("r_nwe", 32'(nwe), 32'd1);
    check("r_nce", 32'(nce), 32'd1);
    check("r_busy", 32'(busy), 32'd0);
    check("r_d", 32'(d), 32'h00);
    check("r_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    log_q.delete();
    for (int i = 0; i < 12; i++) step();
    check("r_no_bytes", 32'(log_q.size()), 32'd0);
    check("r_idle", 32'(busy), 32'd0);
    check("r_cmd_ready_after", 32'(cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
